// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues to a 1-cycle instruction memory,
// buffers returned words in a prefetch FIFO and handles branch redirects and the HALT drain.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        CLOCK,
  input  logic        CLEAR,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  input  logic        stall,
  output logic [15:0] inst_out,
  output logic [15:0] inst_pc,
  output logic        inst_valid,
  output logic        halted,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t         state;
  logic [15:0]    fetch_pc;
  logic           inflight;
  logic [15:0]    inflight_pc;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  logic [CW-1:0]  occupancy;
  logic [15:0]    data_mem [DEPTH];
  logic [15:0]    pc_mem   [DEPTH];

  logic redirect_en;
  logic issue;
  logic push;
  logic pop;

  // Handshake: the head entry is offered while inst_valid=1 and is consumed at the
  // rising edge where stall=0; a redirect in that cycle discards it instead.
  assign redirect_en = redirect && (state != HALTED);
  assign occupancy   = count + CW'(inflight);
  assign issue       = !CLEAR && (state == FETCH) && !redirect && !halt &&
                       (occupancy < CW'(DEPTH));
  assign push        = inflight && !redirect_en;
  assign inst_valid  = (count != '0);
  assign pop         = inst_valid && !stall && !redirect_en;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign inst_out  = inst_valid ? data_mem[rd_ptr] : 16'h0000;
  assign inst_pc   = inst_valid ? pc_mem[rd_ptr]   : 16'h0000;
  assign halted    = (state == HALTED);
  assign state_dbg = state;

  always_comb begin
    count_next = count;
    if (redirect_en)
      count_next = '0;
    else if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  always_ff @(posedge CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 16'h0000;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      count    <= count_next;
      inflight <= issue;
      if (issue)
        inflight_pc <= fetch_pc;

      if (redirect_en)
        fetch_pc <= redirect_pc;
      else if (issue)
        fetch_pc <= fetch_pc + PC_STEP;

      if (redirect_en) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
      end

      // DRAIN ends on the edge that retires the last queued word.
      case (state)
        FETCH:   if (halt) state <= DRAIN;
        DRAIN:   if (count_next == '0 && !issue) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observed while count is nonzero.
  always_ff @(posedge CLOCK) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory returns 16'h1000 + address one cycle after each request.
module tb_fetch_queue;

  logic        CLOCK;
  logic        CLEAR;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        stall;
  logic [15:0] inst_out;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        halted;
  logic [1:0]  state_dbg;

  int n_checks;
  int n_fail;
  logic [15:0] exp_q[$];

  fetch_queue dut (
    .CLOCK      (CLOCK),
    .CLEAR      (CLEAR),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .stall      (stall),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .halted     (halted),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) imem_rdata <= 16'h1000 + imem_addr;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Leaves the bench in cycle 0 (first cycle after CLEAR drops), inputs idle.
  task automatic do_reset();
    CLEAR = 1'b1;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    halt = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    CLEAR = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    CLEAR = 1'b1;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    halt = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    n_checks++;
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", inst_valid); end
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b want 0", halted); end
    n_checks++;
    if (inst_out !== 16'h0000 || inst_pc !== 16'h0000) begin
      n_fail++; $display("FAIL reset_out: got out=%h pc=%h want 0000/0000", inst_out, inst_pc);
    end
    CLEAR = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL first_fetch: got req=%0b addr=%h want 1/0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_straight_line();
    logic [15:0] epc;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin tick(); #1; end
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'(2 * c)) begin
        n_fail++; $display("FAIL straight_req c%0d: got req=%0b addr=%h want 1/%h", c, imem_req, imem_addr, 16'(2 * c));
      end
      n_checks++;
      if (inst_valid !== (c >= 2)) begin
        n_fail++; $display("FAIL straight_valid c%0d: got %0b want %0b", c, inst_valid, (c >= 2));
      end
      if (c >= 2) begin
        epc = 16'(2 * (c - 2));
        n_checks++;
        if (inst_pc !== epc || inst_out !== 16'(16'h1000 + epc)) begin
          n_fail++; $display("FAIL straight_data c%0d: got pc=%h out=%h want %h/%h", c, inst_pc, inst_out, epc, 16'(16'h1000 + epc));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] epc;
    do_reset();
    stall = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin tick(); #1; end
      n_checks++;
      if (imem_req !== (c < 4)) begin
        n_fail++; $display("FAIL bp_req c%0d: got %0b want %0b", c, imem_req, (c < 4));
      end
      if (c >= 2) begin
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h0000 || inst_out !== 16'h1000) begin
          n_fail++; $display("FAIL bp_hold c%0d: got v=%0b pc=%h out=%h want 1/0000/1000", c, inst_valid, inst_pc, inst_out);
        end
      end
    end
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(16'(2 * i));
    tick();
    stall = 1'b0;
    #1;
    for (int c = 8; c < 14; c++) begin
      if (c > 8) begin tick(); #1; end
      epc = exp_q.pop_front();
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== epc || inst_out !== 16'(16'h1000 + epc)) begin
        n_fail++; $display("FAIL bp_release c%0d: got v=%0b pc=%h out=%h want 1/%h/%h", c, inst_valid, inst_pc, inst_out, epc, 16'(16'h1000 + epc));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int c = 1; c < 6; c++) tick();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_noreq: got %0b want 0", imem_req); end
    tick();
    redirect = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      n_fail++; $display("FAIL redir_req: got req=%0b addr=%h want 1/0040", imem_req, imem_addr);
    end
    n_checks++;
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush c6: got valid=%0b pc=%h want 0", inst_valid, inst_pc); end
    tick();
    n_checks++;
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush c7: got valid=%0b pc=%h want 0", inst_valid, inst_pc); end
    tick();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 16'h0040 || inst_out !== 16'h1040) begin
      n_fail++; $display("FAIL redir_target: got v=%0b pc=%h out=%h want 1/0040/1040", inst_valid, inst_pc, inst_out);
    end
    tick();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 16'h0042) begin
      n_fail++; $display("FAIL redir_next: got v=%0b pc=%h want 1/0042", inst_valid, inst_pc);
    end
  endtask

  task automatic test_redirect_full_stall();
    do_reset();
    stall = 1'b1;
    for (int c = 1; c < 5; c++) tick();
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_noreq: got %0b want 0", imem_req); end
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0080;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || inst_pc !== 16'h0000) begin
      n_fail++; $display("FAIL full_redir_cycle: got req=%0b pc=%h want 0/0000", imem_req, inst_pc);
    end
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL full_flush: got valid=%0b want 0", inst_valid); end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin
      n_fail++; $display("FAIL full_refetch: got req=%0b addr=%h want 1/0080", imem_req, imem_addr);
    end
    tick();
    tick();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 16'h0080 || inst_out !== 16'h1080) begin
      n_fail++; $display("FAIL full_target: got v=%0b pc=%h out=%h want 1/0080/1080", inst_valid, inst_pc, inst_out);
    end
  endtask

  task automatic test_halt();
    logic [15:0] epc;
    do_reset();
    stall = 1'b1;
    for (int c = 1; c < 4; c++) tick();
    halt = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_noreq c3: got %0b want 0", imem_req); end
    tick();
    halt = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || halted !== 1'b0 || inst_pc !== 16'h0000) begin
      n_fail++; $display("FAIL halt_drain c4: got req=%0b halted=%0b pc=%h want 0/0/0000", imem_req, halted, inst_pc);
    end
    exp_q.delete();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0004);
    tick();
    stall = 1'b0;
    #1;
    for (int c = 5; c < 8; c++) begin
      if (c > 5) begin tick(); #1; end
      epc = exp_q.pop_front();
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== epc || imem_req !== 1'b0 || halted !== 1'b0) begin
        n_fail++; $display("FAIL halt_deliver c%0d: got v=%0b pc=%h req=%0b halted=%0b want 1/%h/0/0", c, inst_valid, inst_pc, imem_req, halted, epc);
      end
    end
    tick();
    n_checks++;
    if (halted !== 1'b1 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL halt_done: got halted=%0b v=%0b req=%0b want 1/0/0", halted, inst_valid, imem_req);
    end
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    tick();
    redirect = 1'b0;
    #1;
    n_checks++;
    if (halted !== 1'b1 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL halt_redir_ignored: got halted=%0b v=%0b req=%0b want 1/0/0", halted, inst_valid, imem_req);
    end
    tick();
    n_checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL halt_sticky: got halted=%0b req=%0b want 1/0", halted, imem_req);
    end
  endtask

  task automatic test_redirect_with_halt();
    do_reset();
    for (int c = 1; c < 4; c++) tick();
    redirect = 1'b1;
    halt = 1'b1;
    redirect_pc = 16'h0020;
    #1;
    tick();
    redirect = 1'b0;
    halt = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 16'h0020) begin
      n_fail++; $display("FAIL rh_drain: got req=%0b v=%0b halted=%0b addr=%h want 0/0/0/0020", imem_req, inst_valid, halted, imem_addr);
    end
    tick();
    n_checks++;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL rh_halted: got %0b want 1", halted); end
  endtask

  task automatic test_wrap_and_reset();
    logic [15:0] epc;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 16'hFFFC;
    #1;
    tick();
    redirect = 1'b0;
    #1;
    for (int c = 1; c < 4; c++) begin
      if (c > 1) begin tick(); #1; end
      epc = 16'hFFFC + 16'(2 * (c - 1));
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== epc) begin
        n_fail++; $display("FAIL wrap_req c%0d: got req=%0b addr=%h want 1/%h", c, imem_req, imem_addr, epc);
      end
    end
    exp_q.delete();
    exp_q.push_back(16'hFFFC);
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'h0000);
    for (int c = 3; c < 6; c++) begin
      if (c > 3) begin tick(); #1; end
      epc = exp_q.pop_front();
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== epc || inst_out !== 16'(16'h1000 + epc)) begin
        n_fail++; $display("FAIL wrap_data c%0d: got v=%0b pc=%h out=%h want 1/%h/%h", c, inst_valid, inst_pc, inst_out, epc, 16'(16'h1000 + epc));
      end
    end
    tick();
    CLEAR = 1'b1;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0 || inst_pc !== 16'h0000) begin
      n_fail++; $display("FAIL midreset: got v=%0b req=%0b pc=%h want 0/0/0000", inst_valid, imem_req, inst_pc);
    end
    tick();
    CLEAR = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL restart: got req=%0b addr=%h v=%0b want 1/0000/0", imem_req, imem_addr, inst_valid);
    end
    tick();
    tick();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 16'h0000 || inst_out !== 16'h1000) begin
      n_fail++; $display("FAIL restart_data: got v=%0b pc=%h out=%h want 1/0000/1000", inst_valid, inst_pc, inst_out);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_straight_line();
    test_backpressure();
    test_redirect();
    test_redirect_full_stall();
    test_halt();
    test_redirect_with_halt();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
